// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - FSM state encoding (BYTE exists only when LSU_MISALIGN_SPLIT_EN is defined)
//   - helpers that classify a funct3 as legal and an access as misaligned
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RESP   = 3'd2,
    ERR    = 3'd3
`ifdef LSU_MISALIGN_SPLIT_EN
    , BYTE = 3'd4
`endif
  } lsu_state_t;

  // Stores only have signed encodings; unsigned variants are load-only.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic base;
    base = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (we) return base;
    return base || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Size is carried in funct3[1:0]; bytes are never misaligned.
  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
    logic m;
    case (f3[1:0])
      2'b01:   m = a[0];
      2'b10:   m = (a != 2'b00);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational helpers for the LSU.
//   chk_funct3_i/chk_addr_i -> misalign_o : alignment check of an incoming request
//   ext_funct3_i/raw_i      -> ext_o      : sign/zero extension of a right-justified load
//   asm_i/byte_i/idx_i      -> merged_o   : little-endian byte assembly, only built
//                                           when LSU_MISALIGN_SPLIT_EN is defined
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      chk_funct3_i,
  input  logic [1:0]      chk_addr_i,
  output logic            misalign_o,
`ifdef LSU_MISALIGN_SPLIT_EN
  input  logic [XLEN-1:0] asm_i,
  input  logic [7:0]      byte_i,
  input  logic [1:0]      idx_i,
  output logic [XLEN-1:0] merged_o,
`endif
  input  logic [2:0]      ext_funct3_i,
  input  logic [XLEN-1:0] raw_i,
  output logic [XLEN-1:0] ext_o
);

  assign misalign_o = f3_misaligned(chk_funct3_i, chk_addr_i);

`ifdef LSU_MISALIGN_SPLIT_EN
  always_comb begin
    merged_o = asm_i;
    merged_o[8*idx_i +: 8] = byte_i;
  end
`endif

  // Only the low bytes matter: upper bits of the memory word are ignored so the
  // result does not depend on whether the memory pads or replicates.
  always_comb begin
    case (ext_funct3_i)
      F3_B:    ext_o = {{(XLEN-8){raw_i[7]}}, raw_i[7:0]};
      F3_BU:   ext_o = {{(XLEN-8){1'b0}}, raw_i[7:0]};
      F3_H:    ext_o = {{(XLEN-16){raw_i[15]}}, raw_i[15:0]};
      F3_HU:   ext_o = {{(XLEN-16){1'b0}}, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit between execute and a byte-addressed data memory.
// One request in flight; response is a one-cycle pulse (no backpressure).
//   req_*  : request handshake (req_ready high only in IDLE)
//   rsp_*  : registered response pulse, rdata extended per funct3, err on
//            illegal funct3 / misalignment
//   mem_*  : memory port (combinational read, write on posedge when mem_wen)
// Optional: LSU_MISALIGN_SPLIT_EN splits misaligned half/word accesses into
// byte accesses (BYTE state) instead of erroring.
module lsu
  import lsu_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int ERR_ON_MISALIGN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [2:0]      mem_sel,
  output logic            mem_wen,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t      state_q, state_d;
  logic            we_q, we_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]      mem_sel_q, mem_sel_d;
  logic            mem_wen_q, mem_wen_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;

  logic            req_fire;
  logic            misalign;
  logic [XLEN-1:0] ext_raw, ext_data;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [1:0]      cnt_q, cnt_d, cnt_last;
  logic [XLEN-1:0] asm_q, asm_d, asm_merged;
  assign cnt_last = (f3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
  // The last byte is merged in the same cycle it is read, so extension uses
  // the merged word rather than asm_q.
  assign ext_raw  = (state_q == BYTE) ? asm_merged : mem_rdata;
`else
  assign ext_raw  = mem_rdata;
`endif

  assign req_ready = (state_q == IDLE);
  assign req_fire  = req_valid && req_ready;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_sel   = mem_sel_q;
  assign mem_wen   = mem_wen_q;
  assign mem_wdata = mem_wdata_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .chk_funct3_i (req_funct3),
    .chk_addr_i   (req_addr[1:0]),
    .misalign_o   (misalign),
`ifdef LSU_MISALIGN_SPLIT_EN
    .asm_i        (asm_q),
    .byte_i       (mem_rdata[7:0]),
    .idx_i        (cnt_q),
    .merged_o     (asm_merged),
`endif
    .ext_funct3_i (f3_q),
    .raw_i        (ext_raw),
    .ext_o        (ext_data)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= F3_W;
      addr_q      <= '0;
      wdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_sel_q   <= F3_W;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
      cnt_q       <= 2'd0;
      asm_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_sel_q   <= mem_sel_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (!f3_legal(req_we, req_funct3)) begin
            state_d = ERR;
          end else if (misalign) begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state_d = BYTE;
`else
            state_d = (ERR_ON_MISALIGN != 0) ? ERR : ACCESS;
`endif
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: state_d = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
      BYTE:   if (cnt_q == cnt_last) state_d = RESP;
`endif
      RESP:   state_d = IDLE;
      ERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. Memory outputs are registered so they are
  // valid for the whole access cycle and hold afterwards; mem_wen drops by
  // default so each access writes exactly once.
  always_comb begin
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_sel_d   = mem_sel_q;
    mem_wdata_d = mem_wdata_q;
    mem_wen_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
    cnt_d       = cnt_q;
    asm_d       = asm_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (state_d == ACCESS) begin
            mem_addr_d  = req_addr;
            mem_sel_d   = req_funct3;
            mem_wdata_d = req_wdata;
            mem_wen_d   = req_we;
          end else if (state_d == ERR) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end
`ifdef LSU_MISALIGN_SPLIT_EN
          else if (state_d == BYTE) begin
            mem_addr_d  = req_addr;
            mem_sel_d   = F3_B;
            mem_wdata_d = req_wdata;
            mem_wen_d   = req_we;
            cnt_d       = 2'd0;
            asm_d       = '0;
          end
`endif
        end
      end
      ACCESS: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = we_q ? '0 : ext_data;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BYTE: begin
        asm_d = asm_merged;
        if (cnt_q == cnt_last) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? '0 : ext_data;
        end else begin
          cnt_d       = cnt_q + 2'd1;
          mem_addr_d  = addr_q + {{(XLEN-2){1'b0}}, cnt_q + 2'd1};
          mem_sel_d   = F3_B;
          // byte k of the store data rides in mem_wdata[7:0]
          mem_wdata_d = wdata_q >> {cnt_q + 2'd1, 3'b000};
          mem_wen_d   = we_q;
        end
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed bench for lsu with a byte-array memory model and a
// scoreboard of expected responses (data, error flag, arrival cycle).
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [2:0]  mem_sel;
  logic        mem_wen;

  lsu #(.XLEN(32), .ERR_ON_MISALIGN(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_sel(mem_sel), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: returns the addressed bytes right-justified, zero padded.
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;
  assign a0 = mem_addr[7:0];
  assign a1 = a0 + 8'd1;
  assign a2 = a0 + 8'd2;
  assign a3 = a0 + 8'd3;
  always_comb begin
    mem_rdata = {24'h0, mem[a0]};
    if (mem_sel[1:0] == 2'b01) mem_rdata = {16'h0, mem[a1], mem[a0]};
    else if (mem_sel[1:0] == 2'b10) mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
  end
  always @(posedge clk) begin
    if (mem_wen) begin
      mem[a0] <= mem_wdata[7:0];
      if (mem_sel[1:0] != 2'b00) mem[a1] <= mem_wdata[15:8];
      if (mem_sel[1:0] == 2'b10) begin
        mem[a2] <= mem_wdata[23:16];
        mem[a3] <= mem_wdata[31:24];
      end
    end
  end

  // Cycle counter and response/write monitor
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          wen_cnt = 0;
  int          obs_n = 0;
  logic [31:0] obs_rd  [0:63];
  logic        obs_err [0:63];
  int          obs_cyc [0:63];
  always @(negedge clk) begin
    if (mem_wen) wen_cnt <= wen_cnt + 1;
    if (rsp_valid && obs_n < 64) begin
      obs_rd[obs_n]  <= rsp_rdata;
      obs_err[obs_n] <= rsp_err;
      obs_cyc[obs_n] <= cyc;
      obs_n          <= obs_n + 1;
    end
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int exp_total = 0;
  int rd_idx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat, input bit push, output int hs);
    int n;
    exp_t e;
    n = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    hs = cyc;
    if (!req_ready) begin
      chk("hs_timeout", 32'(n), 32'd0);
      req_valid = 1'b0;
    end else begin
      if (push) begin
        e.rdata = er; e.err = ee; e.cyc = cyc + lat;
        sb.push_back(e);
        exp_total++;
      end
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    exp_t e;
    n = 0;
    while (obs_n < exp_total && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (obs_n < exp_total) chk("rsp_timeout", 32'(obs_n), 32'(exp_total));
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (rd_idx < obs_n) begin
        chk($sformatf("rdata#%0d", rd_idx), obs_rd[rd_idx], e.rdata);
        chk($sformatf("err#%0d", rd_idx), {31'h0, obs_err[rd_idx]}, {31'h0, e.err});
        chk($sformatf("lat#%0d", rd_idx), 32'(obs_cyc[rd_idx]), 32'(e.cyc));
      end
      rd_idx++;
    end
    repeat (3) @(posedge clk);
    chk("extra_rsp", 32'(obs_n), 32'(exp_total));
    @(negedge clk);
  endtask

  initial begin
    int h1, h2, w0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_sel", {29'h0, mem_sel}, 32'd2);
    chk("rst_mem_wen", {31'h0, mem_wen}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Preload 0x10..0x13 = 80,7F,12,34 through the DUT; one write cycle.
    w0 = wen_cnt;
    do_req(1'b1, F3_W, 32'h10, 32'h34127F80, 32'h0, 1'b0, 2, 1'b1, h1);
    drain();
    chk("sw10_wen_once", 32'(wen_cnt - w0), 32'd1);

    // Loads, issued back to back
    do_req(1'b0, F3_W,  32'h10, 0, 32'h34127F80, 1'b0, 2, 1'b1, h1);
    do_req(1'b0, F3_B,  32'h10, 0, 32'hFFFFFF80, 1'b0, 2, 1'b1, h2);
    chk("b2b_gap_legal", 32'(h2 - h1), 32'd3);
    do_req(1'b0, F3_BU, 32'h10, 0, 32'h00000080, 1'b0, 2, 1'b1, h1);
    do_req(1'b0, F3_H,  32'h12, 0, 32'h00003412, 1'b0, 2, 1'b1, h1);
    do_req(1'b0, F3_H,  32'h10, 0, 32'h00007F80, 1'b0, 2, 1'b1, h1);
    do_req(1'b0, F3_B,  32'h11, 0, 32'h0000007F, 1'b0, 2, 1'b1, h1);
    do_req(1'b0, F3_B,  32'h13, 0, 32'h00000034, 1'b0, 2, 1'b1, h1);
    drain();

    // Stores of each width
    w0 = wen_cnt;
    do_req(1'b1, F3_W, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, h1);
    drain();
    chk("sw20_wen_once", 32'(wen_cnt - w0), 32'd1);
    do_req(1'b0, F3_W, 32'h20, 0, 32'hDEADBEEF, 1'b0, 2, 1'b1, h1);
    do_req(1'b1, F3_B, 32'h21, 32'h00000055, 32'h0, 1'b0, 2, 1'b1, h1);
    do_req(1'b0, F3_W, 32'h20, 0, 32'hDEAD55EF, 1'b0, 2, 1'b1, h1);
    do_req(1'b1, F3_H, 32'h22, 32'h1234ABCD, 32'h0, 1'b0, 2, 1'b1, h1);
    do_req(1'b0, F3_W, 32'h20, 0, 32'hABCD55EF, 1'b0, 2, 1'b1, h1);
    do_req(1'b0, F3_H, 32'h22, 0, 32'hFFFFABCD, 1'b0, 2, 1'b1, h1);
    do_req(1'b0, F3_HU, 32'h22, 0, 32'h0000ABCD, 1'b0, 2, 1'b1, h1);
    drain();

    // Errors: illegal funct3 for load and store, misalignment
    w0 = wen_cnt;
    do_req(1'b0, 3'b011, 32'h10, 0, 32'h0, 1'b1, 1, 1'b1, h1);
    do_req(1'b0, F3_BU,  32'h10, 0, 32'h00000080, 1'b0, 2, 1'b1, h2);
    chk("b2b_gap_err", 32'(h2 - h1), 32'd2);
    do_req(1'b1, F3_BU,  32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1, h1);
    do_req(1'b1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1, h1);
`ifndef LSU_MISALIGN_SPLIT_EN
    do_req(1'b0, F3_H,   32'h11, 0, 32'h0, 1'b1, 1, 1'b1, h1);
    do_req(1'b1, F3_W,   32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 1'b1, h1);
`endif
    drain();
    chk("err_no_wen", 32'(wen_cnt - w0), 32'd0);
    do_req(1'b0, F3_W, 32'h20, 0, 32'hABCD55EF, 1'b0, 2, 1'b1, h1);
    drain();

`ifdef LSU_MISALIGN_SPLIT_EN
    do_req(1'b0, F3_H, 32'h11, 0, 32'h0000127F, 1'b0, 3, 1'b1, h1);
    do_req(1'b1, F3_W, 32'h30, 32'h0, 32'h0, 1'b0, 2, 1'b1, h1);
    drain();
    w0 = wen_cnt;
    do_req(1'b1, F3_W, 32'h31, 32'h11223344, 32'h0, 1'b0, 5, 1'b1, h1);
    drain();
    chk("split_sw_wen4", 32'(wen_cnt - w0), 32'd4);
    do_req(1'b0, F3_W, 32'h30, 0, 32'h22334400, 1'b0, 2, 1'b1, h1);
    do_req(1'b0, F3_W, 32'h31, 0, 32'h11223344, 1'b0, 5, 1'b1, h1);
    drain();
`endif

    // Reset in the ACCESS cycle of a store aborts it without a response
    do_req(1'b1, F3_W, 32'h40, 32'h01020304, 32'h0, 1'b0, 2, 1'b1, h1);
    drain();
    do_req(1'b1, F3_W, 32'h40, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b0, h1);
    chk("abort_acc_wen", {31'h0, mem_wen}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_wen", {31'h0, mem_wen}, 32'd0);
    chk("abort_ready", {31'h0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_mem_sel", {29'h0, mem_sel}, 32'd2);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drain();
    do_req(1'b0, F3_W, 32'h40, 0, 32'h01020304, 1'b0, 2, 1'b1, h1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
Load/store unit between the RV32I execute stage and the byte-addressed data memory (funct3-selected access, combinational read, write on posedge clk). Accepts one load/store request per handshake, validates funct3 and alignment, and sequences the memory port. Returns a registered, extended load result or an error flag as a one-cycle response pulse. One request in flight at a time.

Parameters:
XLEN, 32, data and address width
ERR_ON_MISALIGN, 1, 1 = misaligned access returns rsp_err (overridden when LSU_MISALIGN_SPLIT_EN is defined)

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  LSU can accept (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data (low bytes used for sb/sh)
rsp_valid  output  1  one-cycle response pulse, no backpressure
rsp_rdata  output  XLEN  load result (0 for stores and errors)
rsp_err  output  1  illegal funct3 or misaligned, valid with rsp_valid
mem_addr  output  XLEN  memory byte address
mem_sel  output  3  memory funct3
mem_wen  output  1  memory write enable
mem_wdata  output  XLEN  memory write data
mem_rdata  input  XLEN  memory read data (combinational)

Behaviour:
- Reset (async, any state): state=IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; mem_addr=0, mem_sel=3'b010, mem_wen=0, mem_wdata=0.
- States: IDLE, ACCESS, BYTE, RESP, ERR.
- IDLE: req_ready=1. On req_valid&&req_ready, capture we/funct3/addr/wdata. Legal loads: 000,001,010,100,101; legal stores: 000,001,010. Illegal -> ERR. Misaligned (half with addr[0]=1, word with addr[1:0]!=0) -> ERR (-> BYTE with macro). Else -> ACCESS.
- ACCESS (1 cycle): drive mem_addr/mem_sel/mem_wdata from captured request; mem_wen=1 only for stores; load data sampled into rsp_rdata at end of cycle. -> RESP.
- RESP: rsp_valid=1, rsp_err=0, one cycle. -> IDLE.
- ERR: rsp_valid=1, rsp_err=1, rsp_rdata=0, no memory access ever (mem_wen=0). -> IDLE.
- Latency: handshake in cycle N -> rsp_valid in N+2 (legal), N+1 (error). Next request accepted N+3 at earliest.
- mem_wen is 0 in every state except ACCESS/BYTE for stores; never two writes per byte.
- Outside access states, mem_* hold last driven values.

Optional Feature:
Macro LSU_MISALIGN_SPLIT_EN. Defined: misaligned legal accesses go to BYTE, issuing n byte accesses (n=2 half, 4 word), one per cycle, address addr+k, mem_sel=000, store byte k = wdata[8k+7:8k]; loads assemble mem_rdata[7:0] little-endian, then sign/zero-extend per funct3; rsp_valid at N+n+1. Reset mid-BYTE aborts; already-written bytes stay written. Undefined: BYTE state absent; misaligned -> ERR.

Decomposition:
- Package lsu_pkg: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum lsu_state_t, helper to classify legal/misaligned.
- Sub-module lsu_align: combinational alignment check plus load byte assembly and sign/zero extension; FSM stays in lsu.

Test Plan:
- Memory bytes 0x10..0x13 = 80,7F,12,34; lw 0x10 -> rsp_rdata=0x34127F80, rsp_err=0, rsp_valid exactly N+2.
- lb 0x10 -> 0xFFFFFF80; lbu 0x10 -> 0x00000080; lh 0x12 -> 0x00003412.
- sw 0x20 wdata 0xDEADBEEF -> mem_wen high exactly one cycle; then lw 0x20 -> 0xDEADBEEF; sb 0x21 wdata 0x55 -> lw 0x20 -> 0xDEAD55EF.
- funct3=011 load, and lh 0x11 without macro -> rsp_err=1, rsp_rdata=0, mem_wen never asserted, rsp_valid at N+1.
- With LSU_MISALIGN_SPLIT_EN: lh 0x11 -> 0x0000127F at N+3; sw 0x31 wdata 0x11223344 -> four sb, lw 0x30 shows bytes 0x31..0x33 = 44,33,22.
- Assert rst during ACCESS of a store -> outputs at reset values immediately, req_ready=1, no rsp_valid for the aborted request.
